icache_refill_unit: RTL and testbench

Sits directly below the instruction cache, on its L2-side refill port. On an icache miss request it issues one line-aligned read to the memory bus, collects BLOCK_WIDTH/MEM_WIDTH response beats, and assembles them into a full cache line. It then returns the line to the icache with a single-cycle ready pulse. It handles one outstanding refill at a time and has no internal line storage beyond the assembly buffer.

---
 rtl/icache_refill_unit.sv | 126 ++++++++++++
 tb/tb_icache_refill_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_unit.sv
// Refill engine below the instruction cache: one line-aligned memory read per miss,
// beats assembled into a full line and returned with a single-cycle ready pulse.
module icache_refill_unit #(
   parameter int ADDR_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 128,
   parameter int MEM_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_in,
   input  logic [ADDR_WIDTH-1:0]  address_in,
   output logic                   ready_out,
   output logic [BLOCK_WIDTH-1:0] data_out,
   output logic                   busy,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_WIDTH-1:0]  mem_req_addr,
   input  logic                   mem_resp_valid,
   input  logic [MEM_WIDTH-1:0]   mem_resp_data
);

   localparam int BEATS    = BLOCK_WIDTH / MEM_WIDTH;
   localparam int OFF_BITS = $clog2(BLOCK_WIDTH / 8);
   localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RECV = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [ADDR_WIDTH-1:0]  saved_addr;
   logic [CNT_W-1:0]       beat_cnt;
   logic [BLOCK_WIDTH-1:0] line_buf;

   logic latch_addr;
   logic req_grant;
   logic beat_wr;

   // Handshakes: a request transfers in the cycle mem_req_valid and mem_req_ready are
   // both high, with mem_req_addr held stable until then; a response beat transfers in
   // every RECV cycle with mem_resp_valid high (no backpressure on responses).
   always_comb begin
      state_next = state;
      latch_addr = 1'b0;
      req_grant  = 1'b0;
      beat_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (valid_in) begin
               latch_addr = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               req_grant  = 1'b1;
               state_next = RECV;
            end
         end
         RECV: begin
            if (mem_resp_valid) begin
               beat_wr = 1'b1;
               if (beat_cnt == LAST_BEAT) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         saved_addr <= '0;
         beat_cnt   <= '0;
         line_buf   <= '0;
      end else begin
         if (latch_addr) begin
            saved_addr <= address_in & LINE_MASK;
         end

         if (req_grant) begin
            beat_cnt <= '0;
         end else if (beat_wr) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
         end

         // Only the addressed slot changes; the rest keep the previous line's data.
         if (beat_wr) begin
            for (int k = 0; k < BEATS; k++) begin
               if (beat_cnt == CNT_W'(k)) begin
                  line_buf[k*MEM_WIDTH +: MEM_WIDTH] <= mem_resp_data;
               end
            end
         end
      end
   end

   assign ready_out     = (state == DONE);
   assign busy          = (state != IDLE);
   assign mem_req_valid = (state == REQ);
   assign mem_req_addr  = saved_addr;
   assign data_out      = line_buf;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Bench for icache_refill_unit: table of refill transactions plus hand-written reset
// sequences; completed lines are checked against a queue of expected lines.
module tb_icache_refill_unit;

   localparam int AW = 32;
   localparam int BW = 128;
   localparam int MW = 32;
   localparam int NB = BW / MW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_in = 1'b0;
   logic [AW-1:0] address_in = '0;
   logic          ready_out;
   logic [BW-1:0] data_out;
   logic          busy;
   logic          mem_req_valid;
   logic          mem_req_ready = 1'b0;
   logic [AW-1:0] mem_req_addr;
   logic          mem_resp_valid = 1'b0;
   logic [MW-1:0] mem_resp_data = '0;

   always #5 clk = ~clk;

   icache_refill_unit #(
      .ADDR_WIDTH  (AW),
      .BLOCK_WIDTH (BW),
      .MEM_WIDTH   (MW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_in       (valid_in),
      .address_in     (address_in),
      .ready_out      (ready_out),
      .data_out       (data_out),
      .busy           (busy),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   typedef struct {
      logic [AW-1:0]          addr;
      logic [AW-1:0]          exp_addr;
      logic [NB-1:0][MW-1:0]  beats;
      int                     gap;
      int                     req_wait;
      bit                     noise;
      bit                     hold;
   } vec_t;

   vec_t          vecs[7];
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] exp_line;
   int            checks = 0;
   int            errors = 0;
   int            pulses = 0;
   int            exp_pulses = 0;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every ready pulse must match the oldest outstanding expected line.
   always @(negedge clk) begin
      if (rst_n && ready_out) begin
         pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: got ready_out=1 with data %h expected no pulse", data_out);
         end else begin
            exp_line = exp_q.pop_front();
            if (data_out !== exp_line) begin
               errors++;
               $display("FAIL line_data: got %h expected %h", data_out, exp_line);
            end
         end
      end
   end

   task automatic recv_cycle_checks(input vec_t v);
      check("recv_ready_low", ready_out, 1'b0);
      check("recv_busy", busy, 1'b1);
      check("recv_no_req", mem_req_valid, 1'b0);
      check("recv_addr_held", mem_req_addr, v.exp_addr);
   endtask

   task automatic refill(input vec_t v);
      if (v.noise) begin
         valid_in       = 1'b0;
         mem_resp_valid = 1'b1;
         mem_resp_data  = $urandom;
         step();
         check("idle_stray_busy", busy, 1'b0);
         check("idle_stray_req", mem_req_valid, 1'b0);
         mem_resp_valid = 1'b0;
      end
      check("idle_busy", busy, 1'b0);
      valid_in   = 1'b1;
      address_in = v.addr;
      step();
      valid_in   = 1'b0;
      address_in = $urandom;
      for (int i = 0; i <= v.req_wait; i++) begin
         check("req_valid", mem_req_valid, 1'b1);
         check("req_addr", mem_req_addr, v.exp_addr);
         check("req_busy", busy, 1'b1);
         check("req_ready_low", ready_out, 1'b0);
         mem_req_ready  = (i == v.req_wait);
         mem_resp_valid = v.noise && (i < v.req_wait);
         mem_resp_data  = $urandom;
         if (v.noise) begin
            valid_in   = 1'($urandom_range(0, 1));
            address_in = $urandom;
         end
         step();
      end
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      exp_q.push_back(v.beats);
      exp_pulses++;
      for (int k = 0; k < NB; k++) begin
         for (int g = 0; g < ((k > 0) ? v.gap : 0); g++) begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (v.noise) begin
               valid_in   = 1'($urandom_range(0, 1));
               address_in = $urandom;
            end
            recv_cycle_checks(v);
            step();
         end
         mem_resp_valid = 1'b1;
         mem_resp_data  = v.beats[k];
         if (v.noise) begin
            valid_in   = 1'($urandom_range(0, 1));
            address_in = $urandom;
         end
         recv_cycle_checks(v);
         step();
      end
      mem_resp_valid = 1'b0;
      valid_in       = v.hold;
      check("done_ready", ready_out, 1'b1);
      check("done_busy", busy, 1'b1);
      check("done_no_req", mem_req_valid, 1'b0);
      check("done_data", data_out, v.beats);
      check("done_addr", mem_req_addr, v.exp_addr);
      step();
      check("after_done_ready", ready_out, 1'b0);
      check("after_done_busy", busy, 1'b0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, ready_out, 1'b0);
      check({tag, "_data"}, data_out, '0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_req_valid"}, mem_req_valid, 1'b0);
      check({tag, "_req_addr"}, mem_req_addr, '0);
   endtask

   initial begin
      // addr, exp_addr, beats {slot3..slot0}, gap, req_wait, noise, hold
      vecs[0] = '{32'h0000_1236, 32'h0000_1230,
                  {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}, 0, 0, 1'b0, 1'b0};
      vecs[1] = '{32'h8000_00FF, 32'h8000_00F0,
                  {32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001}, 0, 5, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_0040, 32'h0000_0040,
                  {$urandom, $urandom, $urandom, $urandom}, 2, 0, 1'b0, 1'b0};
      vecs[3] = '{32'h4444_5678, 32'h4444_5670,
                  {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000}, 1, 2, 1'b1, 1'b0};
      vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF0,
                  {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}, 0, 0, 1'b0, 1'b1};
      vecs[5] = '{32'h1234_5670, 32'h1234_5670,
                  {32'hBEEF_0013, 32'hBEEF_0012, 32'hBEEF_0011, 32'hBEEF_0010}, 0, 1, 1'b0, 1'b0};
      vecs[6] = '{32'h0000_ABCD, 32'h0000_ABC0,
                  {$urandom, $urandom, $urandom, $urandom}, 1, 0, 1'b0, 1'b0};

      #1;
      check_all_zero("reset");
      step();
      step();
      check_all_zero("reset_edge");
      rst_n = 1'b1;
      step();
      check_all_zero("post_reset");

      for (int i = 0; i < 6; i++) begin
         refill(vecs[i]);
      end
      repeat (2) step();

      // Reset in the middle of a refill, then stray beats after release.
      valid_in   = 1'b1;
      address_in = 32'h0000_2008;
      step();
      valid_in = 1'b0;
      check("mid_req_addr", mem_req_addr, 32'h0000_2000);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h5555_0000;
      step();
      mem_resp_data = 32'h5555_0001;
      step();
      mem_resp_valid = 1'b0;
      check("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      step();
      check_all_zero("mid_reset_edge");
      rst_n = 1'b1;
      for (int k = 2; k < NB; k++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'h6666_0000 + 32'(k);
         step();
         check("stray_busy", busy, 1'b0);
         check("stray_ready", ready_out, 1'b0);
         check("stray_data", data_out, '0);
      end
      mem_resp_valid = 1'b0;
      repeat (3) begin
         step();
         check("stray_idle_ready", ready_out, 1'b0);
      end

      refill(vecs[6]);
      repeat (3) step();

      check("pulse_count", 32'(pulses), 32'(exp_pulses));
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
